wb_bus_ctrl: RTL and testbench

Parametrised Wishbone classic single-master/N-slave interconnect. It generalises the combinational address mux between the tenyr Core data port and its memory and devices. Address decode is registered, and a transaction FSM is added. Added behaviour: a built-in default responder for unmapped addresses, a per-transaction timeout watchdog that generates bus errors, and a captured fault-address register. It sits between the Core data port and the RAM and device slaves in the top level.

---
 rtl/wb_bus_ctrl.sv | 146 ++++++++++++++
 tb/tb_wb_bus_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_ctrl.sv
// Wishbone classic single-master / N-slave interconnect with registered
// decode, unmapped-address responder, timeout watchdog and fault capture.
module wb_bus_ctrl #(
    parameter int                      NSLAVES      = 6,
    parameter int                      AW           = 32,
    parameter int                      DW           = 32,
    parameter logic [NSLAVES*AW-1:0]   MATCH_ADDR   = '0,
    parameter logic [NSLAVES*AW-1:0]   MATCH_MASK   = '0,
    parameter int                      TIMEOUT      = 15,
    parameter logic [DW-1:0]           DEFAULT_DATA = {DW{1'b1}},
    parameter bit                      ERR_ON_MISS  = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AW-1:0]              wbm_adr_i,
    input  logic [DW-1:0]              wbm_dat_i,
    output logic [DW-1:0]              wbm_dat_o,
    input  logic                       wbm_we_i,
    input  logic [DW/8-1:0]            wbm_sel_i,
    input  logic                       wbm_stb_i,
    input  logic                       wbm_cyc_i,
    output logic                       wbm_ack_o,
    output logic                       wbm_err_o,
    output logic                       wbm_rty_o,
    output logic [NSLAVES*AW-1:0]      wbs_adr_o,
    output logic [NSLAVES*DW-1:0]      wbs_dat_o,
    input  logic [NSLAVES*DW-1:0]      wbs_dat_i,
    output logic [NSLAVES-1:0]         wbs_we_o,
    output logic [NSLAVES*DW/8-1:0]    wbs_sel_o,
    output logic [NSLAVES-1:0]         wbs_stb_o,
    output logic [NSLAVES-1:0]         wbs_cyc_o,
    input  logic [NSLAVES-1:0]         wbs_ack_i,
    input  logic [NSLAVES-1:0]         wbs_err_i,
    input  logic [NSLAVES-1:0]         wbs_rty_i,
    output logic                       timeout_o,
    output logic [AW-1:0]              fault_adr_o
);

    localparam bit WD_EN = (TIMEOUT > 0);
    localparam int TW    = WD_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] LIM = WD_EN ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t               r_state;
    logic [NSLAVES-1:0]   r_sel;
    logic                 r_miss;
    logic [TW-1:0]        r_timer;
    logic [AW-1:0]        r_fault;

    logic [NSLAVES-1:0]   w_dec;
    logic [DW-1:0]        w_rdat;
    logic                 w_act;
    logic                 w_go;
    logic                 w_s_ack;
    logic                 w_s_err;
    logic                 w_s_rty;
    logic                 w_s_any;
    logic                 w_timeout;
    logic                 w_err;
    logic                 w_rty;
    logic                 w_ack;
    logic                 w_gate;

    // Descending scan so the lowest matching index is the one kept.
    always_comb begin
        w_dec = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (((wbm_adr_i ^ MATCH_ADDR[i*AW +: AW])
                 & MATCH_MASK[i*AW +: AW]) == '0) begin
                w_dec    = '0;
                w_dec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_rdat = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (r_sel[i]) w_rdat = w_rdat | wbs_dat_i[i*DW +: DW];
        end
    end

    assign w_act   = (r_state == ACTIVE) && !reset;
    assign w_go    = w_act && wbm_cyc_i;
    assign w_s_ack = |(wbs_ack_i & r_sel);
    assign w_s_err = |(wbs_err_i & r_sel);
    assign w_s_rty = |(wbs_rty_i & r_sel);
    assign w_s_any = w_s_ack || w_s_err || w_s_rty;

    assign w_timeout = WD_EN && w_go && !r_miss && !w_s_any
                       && (r_timer == LIM);

    assign w_err = w_go && (w_s_err || (r_miss && ERR_ON_MISS) || w_timeout);
    assign w_rty = w_go && !w_err && w_s_rty;
    assign w_ack = w_go && !w_err && !w_rty
                   && (w_s_ack || (r_miss && !ERR_ON_MISS));

    assign wbm_err_o   = w_err;
    assign wbm_rty_o   = w_rty;
    assign wbm_ack_o   = w_ack;
    assign timeout_o   = w_timeout;
    assign fault_adr_o = r_fault;

    assign wbm_dat_o = !w_act ? '0 : (r_miss ? DEFAULT_DATA : w_rdat);

    assign w_gate    = w_go && !w_timeout;
    assign wbs_cyc_o = {NSLAVES{w_gate}} & r_sel;
    assign wbs_stb_o = wbs_cyc_o & {NSLAVES{wbm_stb_i}};

    assign wbs_adr_o = {NSLAVES{wbm_adr_i}};
    assign wbs_dat_o = {NSLAVES{wbm_dat_i}};
    assign wbs_we_o  = {NSLAVES{wbm_we_i}};
    assign wbs_sel_o = {NSLAVES{wbm_sel_i}};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_miss  <= 1'b0;
            r_timer <= '0;
            r_fault <= '0;
        end else begin
            if (w_err) r_fault <= wbm_adr_i;
            unique case (r_state)
                IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        r_state <= ACTIVE;
                        r_sel   <= w_dec;
                        r_miss  <= ~|w_dec;
                        r_timer <= '0;
                    end
                end
                ACTIVE: begin
                    if (!wbm_cyc_i || w_ack || w_err || w_rty) begin
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bus_ctrl.sv
// Randomised scoreboard bench for wb_bus_ctrl: two instances that differ
// only in miss policy, checked against a transaction-level model.
module tb_wb_bus_ctrl;

    localparam int NS = 3;
    localparam int TO = 8;
    localparam logic [NS*32-1:0] MADDR = {32'h200, 32'h100, 32'h1000};
    localparam logic [NS*32-1:0] MMASK = {32'hfffffffc, 32'hfffffffe,
                                          32'hfffff000};

    logic               clk = 1'b0;
    logic               reset;
    logic [31:0]        m_adr, m_wdat;
    logic               m_we, m_stb, m_cyc;
    logic [3:0]         m_sel;
    logic [NS*32-1:0]   s_rdat;
    logic [NS-1:0]      s_ack, s_err, s_rty;

    logic [31:0]        d_dat   [2];
    logic               d_ack   [2];
    logic               d_err   [2];
    logic               d_rty   [2];
    logic               d_to    [2];
    logic [31:0]        d_fault [2];
    logic [NS*32-1:0]   d_sadr  [2];
    logic [NS*32-1:0]   d_sdat  [2];
    logic [NS-1:0]      d_swe   [2];
    logic [NS*4-1:0]    d_ssel  [2];
    logic [NS-1:0]      d_sstb  [2];
    logic [NS-1:0]      d_scyc  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_bus_ctrl #(
            .NSLAVES(NS), .AW(32), .DW(32),
            .MATCH_ADDR(MADDR), .MATCH_MASK(MMASK),
            .TIMEOUT(TO), .DEFAULT_DATA(32'hffffffff),
            .ERR_ON_MISS(g == 1)
        ) u_dut (
            .clk(clk), .reset(reset),
            .wbm_adr_i(m_adr), .wbm_dat_i(m_wdat), .wbm_dat_o(d_dat[g]),
            .wbm_we_i(m_we), .wbm_sel_i(m_sel),
            .wbm_stb_i(m_stb), .wbm_cyc_i(m_cyc),
            .wbm_ack_o(d_ack[g]), .wbm_err_o(d_err[g]), .wbm_rty_o(d_rty[g]),
            .wbs_adr_o(d_sadr[g]), .wbs_dat_o(d_sdat[g]), .wbs_dat_i(s_rdat),
            .wbs_we_o(d_swe[g]), .wbs_sel_o(d_ssel[g]),
            .wbs_stb_o(d_sstb[g]), .wbs_cyc_o(d_scyc[g]),
            .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
            .timeout_o(d_to[g]), .fault_adr_o(d_fault[g])
        );
    end

    always #5 clk = ~clk;

    // kind encoding: {err, rty, ack}
    typedef struct {
        int          cyc;
        logic [2:0]  k0;
        logic [2:0]  k1;
        logic [31:0] dat;
    } rsp_t;

    rsp_t        q[$];
    int          cyc_n = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          chk_en = 0;
    bit          dat_chk = 1;
    logic [2:0]  exp_stb;
    logic        exp_to;
    logic [31:0] exp_dat;
    logic [31:0] exp_fault [2];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h",
                     nm, cyc_n, got, exp);
        end
    endtask

    // Monitor: per-cycle outputs plus response scoreboard.
    always @(negedge clk) begin
        logic [2:0] g0, g1;
        rsp_t e;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("stb%0d", d), 32'(d_sstb[d]), 32'(exp_stb));
                chk($sformatf("cyc%0d", d), 32'(d_scyc[d]), 32'(exp_stb));
                chk($sformatf("timeout%0d", d), 32'(d_to[d]), 32'(exp_to));
                chk($sformatf("fault%0d", d), d_fault[d], exp_fault[d]);
                if (dat_chk)
                    chk($sformatf("rdat%0d", d), d_dat[d], exp_dat);
            end
            for (int i = 0; i < NS; i++) begin
                chk("bc_adr", d_sadr[0][i*32 +: 32], m_adr);
                chk("bc_dat", d_sdat[0][i*32 +: 32], m_wdat);
                chk("bc_we", 32'(d_swe[0][i]), 32'(m_we));
                chk("bc_sel", 32'(d_ssel[0][i*4 +: 4]), 32'(m_sel));
            end
            g0 = {d_err[0], d_rty[0], d_ack[0]};
            g1 = {d_err[1], d_rty[1], d_ack[1]};
            while (q.size() > 0 && q[0].cyc < cyc_n) begin
                e = q.pop_front();
                chk("missing_rsp", 32'(0), 32'(e.k0));
            end
            if (g0 != 3'b000 || g1 != 3'b000) begin
                if (q.size() > 0 && q[0].cyc == cyc_n) begin
                    e = q.pop_front();
                    chk("rsp_kind0", 32'(g0), 32'(e.k0));
                    chk("rsp_kind1", 32'(g1), 32'(e.k1));
                    chk("rsp_dat0", d_dat[0], e.dat);
                    chk("rsp_dat1", d_dat[1], e.dat);
                end else begin
                    chk("spurious_rsp0", 32'(g0), 32'(0));
                    chk("spurious_rsp1", 32'(g1), 32'(0));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "bench timeout");
    end

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & MMASK[i*32 +: 32]) == (MADDR[i*32 +: 32] & MMASK[i*32 +: 32]))
                return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise(input int hit);
        logic [2:0] m;
        m = (hit >= 0) ? 3'(1 << hit) : 3'b000;
        s_ack = 3'($urandom) & ~m;
        s_err = 3'($urandom) & ~m;
        s_rty = 3'($urandom) & ~m;
        s_rdat = {$urandom, $urandom, $urandom};
    endtask

    // mode: 0 none, 1 ack, 2 err, 3 rty, 4 ack+err, 5 ack+rty
    task automatic xfer(input logic [31:0] adr, input logic we,
                        input logic [31:0] wd, input logic [3:0] sel,
                        input int mode, input int lat,
                        input int abort_k, input int rst_k);
        int         hit;
        logic [2:0] oh;
        logic [2:0] kind;
        rsp_t       r;
        bit         done;
        hit = decode(adr);
        oh  = (hit >= 0) ? 3'(1 << hit) : 3'b000;
        m_adr = adr; m_wdat = wd; m_we = we; m_sel = sel;
        m_cyc = 1'b1; m_stb = 1'b1;
        noise(-1);
        exp_stb = '0; exp_to = 1'b0; exp_dat = '0; dat_chk = 1;
        done = 0;
        for (int k = 1; k <= TO && !done; k++) begin
            tick();
            noise(hit);
            exp_to  = 1'b0;
            exp_stb = oh;
            exp_dat = (hit < 0) ? 32'hffffffff : s_rdat[hit*32 +: 32];
            if (k == rst_k) begin
                reset = 1'b1; exp_stb = '0; dat_chk = 0;
                tick();
                reset = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
                exp_fault[0] = '0; exp_fault[1] = '0;
                noise(-1);
                exp_stb = '0; exp_dat = '0; dat_chk = 1;
                return;
            end
            if (k == abort_k) begin
                m_cyc = 1'b0; m_stb = 1'b0; exp_stb = '0;
                tick();
                noise(-1);
                exp_dat = '0;
                return;
            end
            r.cyc = cyc_n; r.dat = exp_dat;
            if (hit < 0) begin
                exp_stb = '0;
                r.k0 = 3'b001; r.k1 = 3'b100; done = 1;
            end else if (k == lat + 1 && mode != 0) begin
                if (mode inside {1, 4, 5}) s_ack[hit] = 1'b1;
                if (mode inside {2, 4})    s_err[hit] = 1'b1;
                if (mode inside {3, 5})    s_rty[hit] = 1'b1;
                kind = (mode inside {2, 4}) ? 3'b100 :
                       (mode inside {3, 5}) ? 3'b010 : 3'b001;
                r.k0 = kind; r.k1 = kind; done = 1;
            end else if (k == TO) begin
                exp_stb = '0; exp_to = 1'b1;
                r.k0 = 3'b100; r.k1 = 3'b100; done = 1;
            end
            if (done) q.push_back(r);
        end
        tick();
        if (r.k0[2]) exp_fault[0] = adr;
        if (r.k1[2]) exp_fault[1] = adr;
        m_cyc = 1'b0; m_stb = 1'b0;
        noise(-1);
        exp_stb = '0; exp_to = 1'b0; exp_dat = '0;
    endtask

    function automatic logic [31:0] rand_adr();
        case ($urandom_range(0, 4))
            0: return 32'h1000 | 32'($urandom_range(0, 4095));
            1: return 32'h100 | 32'($urandom_range(0, 1));
            2: return 32'h200 | 32'($urandom_range(0, 3));
            3: return $urandom;
            default: return 32'h102 | 32'($urandom_range(0, 5));
        endcase
    endfunction

    initial begin
        int ab, rs;
        reset = 1'b1;
        m_adr = '0; m_wdat = '0; m_we = 1'b0; m_sel = '0;
        m_stb = 1'b0; m_cyc = 1'b0;
        s_rdat = '0; s_ack = '0; s_err = '0; s_rty = '0;
        exp_stb = '0; exp_to = 1'b0; exp_dat = '0;
        exp_fault[0] = '0; exp_fault[1] = '0;
        tick();
        chk_en = 1;
        tick();
        reset = 1'b0;
        tick();

        xfer(32'h1004, 1'b0, 32'h0,  4'hf, 1, 0, 0, 0);
        xfer(32'h101,  1'b1, 32'h55, 4'h1, 1, 1, 0, 0);
        xfer(32'h8000, 1'b0, 32'h0,  4'hf, 1, 0, 0, 0);
        xfer(32'h200,  1'b0, 32'h0,  4'hf, 0, 0, 0, 0);
        xfer(32'h202,  1'b0, 32'h0,  4'hf, 4, 2, 0, 0);
        xfer(32'h100,  1'b0, 32'h0,  4'hf, 1, 3, 0, 0);
        xfer(32'h1000, 1'b0, 32'h0,  4'hf, 1, 5, 3, 0);
        xfer(32'h1008, 1'b1, 32'h12, 4'h3, 1, 5, 0, 2);
        xfer(32'h1010, 1'b0, 32'h0,  4'hf, 1, 0, 0, 0);
        xfer(32'h203,  1'b0, 32'h0,  4'hf, 1, 7, 0, 0);
        xfer(32'h201,  1'b0, 32'h0,  4'hf, 1, 8, 0, 0);
        xfer(32'h101,  1'b0, 32'h0,  4'hf, 3, 1, 0, 0);
        xfer(32'h100,  1'b0, 32'h0,  4'hf, 5, 0, 0, 0);
        tick();

        for (int n = 0; n < 300; n++) begin
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0;
            rs = (ab == 0 && $urandom_range(0, 14) == 0)
                 ? int'($urandom_range(1, 4)) : 0;
            xfer(rand_adr(), 1'($urandom), $urandom, 4'($urandom),
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 9)),
                 ab, rs);
            if ($urandom_range(0, 2) == 0) tick();
        end

        tick();
        tick();
        chk("queue_empty", 32'(q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
